// File: rtl/zsdram_access_arbiter_pkg.sv
// Shared widths, FSM encoding and defaults for the SDRAM access arbiter.
package zsdram_access_arbiter_pkg;

  localparam int ADDR_W      = 24;
  localparam int DATA_W      = 16;
  localparam int DEF_NUM_REQ = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACK     = 2'd1,
    ST_OWN     = 2'd2,
    ST_RELEASE = 2'd3
  } arbState_t;

  // Channel index width; kept at least 1 so a single-channel build still has a legal vector.
  function automatic int idWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/zarb_rr_picker.sv
// Combinational round-robin selector: the first requesting channel after lastOwner wins.
module zarb_rr_picker
  import zsdram_access_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IDW = idWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     lastOwner,
  output logic               grantValid,
  output logic [IDW-1:0]     grantId
);

  int idx;

  // Scan from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    grantValid = 1'b0;
    grantId    = '0;
    idx        = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = (int'(lastOwner) + off) % NUM_REQ;
      if (req[idx]) begin
        grantValid = 1'b1;
        grantId    = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/zsdram_access_arbiter.sv
// Round-robin owner arbitration for the shared SDRAM glue port.
// Optional ownership watchdog enabled by defining ZSDRAM_ARB_WDOG_EN.
module zsdram_access_arbiter
  import zsdram_access_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int WDOG_CYCLES = 65536,
  localparam int IDW = idWidth(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        iReq,
  output logic [NUM_REQ-1:0]        oAck,
  input  logic [NUM_REQ-1:0]        iDone,
  input  logic [NUM_REQ-1:0]        iRd_Req_Bus,
  input  logic [NUM_REQ-1:0]        iWr_Req_Bus,
  input  logic [NUM_REQ*ADDR_W-1:0] iRd_Addr_Bus,
  input  logic [NUM_REQ*ADDR_W-1:0] iWr_Addr_Bus,
  input  logic [NUM_REQ*DATA_W-1:0] iWr_Data_Bus,
  output logic [NUM_REQ-1:0]        oRd_Done_Bus,
  output logic [NUM_REQ-1:0]        oWr_Done_Bus,
  output logic [DATA_W-1:0]         oRd_Data,
  output logic                      oSDRAM_Rd_Req,
  output logic                      oSDRAM_Wr_Req,
  output logic [ADDR_W-1:0]         oSDRAM_Rd_Addr,
  output logic [ADDR_W-1:0]         oSDRAM_Wr_Addr,
  output logic [DATA_W-1:0]         oSDRAM_Wr_Data,
  input  logic                      iSDRAM_Rd_Done,
  input  logic                      iSDRAM_Wr_Done,
  input  logic [DATA_W-1:0]         iSDRAM_Data,
  output logic                      oOwner_Valid,
  output logic [IDW-1:0]            oOwner_Id,
  output logic                      oWdog_Err,
  output logic [IDW-1:0]            oWdog_Id
);

  arbState_t      state;
  logic [IDW-1:0] lastOwner;
  logic           pickValid;
  logic [IDW-1:0] pickId;
  logic           inOwn;
  logic           ownerDone;
  logic           routedDone;
  logic           wdogFire;

  logic [ADDR_W-1:0] rdAddr [NUM_REQ];
  logic [ADDR_W-1:0] wrAddr [NUM_REQ];
  logic [DATA_W-1:0] wrData [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign rdAddr[gi] = iRd_Addr_Bus[gi*ADDR_W +: ADDR_W];
      assign wrAddr[gi] = iWr_Addr_Bus[gi*ADDR_W +: ADDR_W];
      assign wrData[gi] = iWr_Data_Bus[gi*DATA_W +: DATA_W];
    end
  endgenerate

  zarb_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (iReq),
    .lastOwner  (lastOwner),
    .grantValid (pickValid),
    .grantId    (pickId)
  );

  assign inOwn      = (state == ST_OWN);
  assign ownerDone  = inOwn && iDone[oOwner_Id];
  assign routedDone = inOwn && (iSDRAM_Rd_Done || iSDRAM_Wr_Done);
  assign oRd_Data   = iSDRAM_Data;

  // Zero-latency routing from the registered owner; nothing leaks outside OWN.
  always_comb begin
    oSDRAM_Rd_Req  = 1'b0;
    oSDRAM_Wr_Req  = 1'b0;
    oSDRAM_Rd_Addr = '0;
    oSDRAM_Wr_Addr = '0;
    oSDRAM_Wr_Data = '0;
    oRd_Done_Bus   = '0;
    oWr_Done_Bus   = '0;
    if (inOwn) begin
      oSDRAM_Rd_Req           = iRd_Req_Bus[oOwner_Id];
      oSDRAM_Wr_Req           = iWr_Req_Bus[oOwner_Id];
      oSDRAM_Rd_Addr          = rdAddr[oOwner_Id];
      oSDRAM_Wr_Addr          = wrAddr[oOwner_Id];
      oSDRAM_Wr_Data          = wrData[oOwner_Id];
      oRd_Done_Bus[oOwner_Id] = iSDRAM_Rd_Done;
      oWr_Done_Bus[oOwner_Id] = iSDRAM_Wr_Done;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      lastOwner    <= IDW'(NUM_REQ - 1);
      oAck         <= '0;
      oOwner_Valid <= 1'b0;
      oOwner_Id    <= '0;
    end else begin
      oAck <= '0;
      case (state)
        ST_IDLE: begin
          if (pickValid) begin
            oOwner_Id    <= pickId;
            oAck[pickId] <= 1'b1;
            state        <= ST_ACK;
          end
        end
        ST_ACK: begin
          oOwner_Valid <= 1'b1;
          state        <= ST_OWN;
        end
        ST_OWN: begin
          if (ownerDone || wdogFire) begin
            lastOwner    <= oOwner_Id;
            oOwner_Valid <= 1'b0;
            state        <= ST_RELEASE;
          end
        end
        ST_RELEASE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

`ifdef ZSDRAM_ARB_WDOG_EN
  localparam int WCW = $clog2(WDOG_CYCLES) + 1;
  logic [WCW-1:0] wdogCnt;

  // Routed SDRAM traffic proves the owner is alive, so it defers the forced release.
  assign wdogFire = inOwn && !ownerDone && !routedDone
                    && (wdogCnt == WCW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wdogCnt   <= '0;
      oWdog_Err <= 1'b0;
      oWdog_Id  <= '0;
    end else begin
      oWdog_Err <= wdogFire;
      if (wdogFire)
        oWdog_Id <= oOwner_Id;
      if (state == ST_ACK || routedDone)
        wdogCnt <= '0;
      else if (inOwn)
        wdogCnt <= wdogCnt + WCW'(1);
    end
  end
`else
  wire unusedWdogCfg = (WDOG_CYCLES == 0);
  assign wdogFire  = 1'b0;
  assign oWdog_Err = 1'b0;
  assign oWdog_Id  = '0;
`endif

endmodule
